ctrl_sequencer: RTL and testbench

- Fetch/decode/execute control FSM for the 8-bit microprocessor.
- Consumes the instruction register output (ir_in) and drives every datapath strobe: PC, MAR, memory read/write, IR load, ACC/ALU and OUT register.
- Issues the IR-load strobe that captures the instruction, then reads the registered instruction back to sequence execution.
- Sits between the IR register and the datapath.

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/ctrl_timeout_cnt.sv | 30 +++
 rtl/ctrl_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_ctrl_sequencer.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared opcode, ALU-op and sequencer state definitions for the 8-bit CPU.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package cpu_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_STA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_JMP = 4'h5;
    localparam logic [3:0] OP_JZ  = 4'h6;
    localparam logic [3:0] OP_OUT = 4'h7;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;

    typedef enum logic [2:0] {
        ST_FETCH    = 3'd0,
        ST_FETCH_RD = 3'd1,
        ST_DECODE   = 3'd2,
        ST_MEM_RD   = 3'd3,
        ST_MEM_WR   = 3'd4,
        ST_HALT     = 3'd5
    } state_t;

endpackage

// File: rtl/ctrl_timeout_cnt.sv
// Memory-wait cycle counter; expire flags the LIMIT-th consecutive unready cycle.
// Latency: expire is combinational from the count and inc; the count updates next edge.
// Backpressure: none; LIMIT=0 keeps expire low forever.
module ctrl_timeout_cnt #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    localparam int CW   = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
    localparam int LAST = (LIMIT > 0) ? LIMIT - 1 : 0;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    // cnt holds the waits already spent, so the current cycle is number cnt+1.
    assign expire = (LIMIT != 0) && inc && (cnt == CW'(LAST));

endmodule

// File: rtl/ctrl_sequencer.sv
// Fetch/decode/execute control FSM; CTRL_ILLEGAL_TRAP_EN traps opcodes 8-E into HALT.
// Latency: 3 cycles NOP/JMP/JZ/OUT, 4 cycles LDA/ADD/SUB/STA at zero-wait memory.
// Backpressure: stalls in FETCH_RD/MEM_RD/MEM_WR until mem_ready; TIMEOUT_CYC waits -> bus_err.
module ctrl_sequencer
    import cpu_pkg::*;
#(
    parameter int OPW         = 4,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ir_in,
    input  logic       mem_ready,
    input  logic       zero_flag,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       mar_src,
    output logic       mar_load,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       ir_load,
    output logic       acc_load,
    output logic [1:0] alu_op,
    output logic       out_load,
    output logic       halted,
    output logic       bus_err,
    output logic [2:0] state_dbg
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    output logic       illegal_op
`endif
);

    state_t         state, state_n;
    logic [OPW-1:0] opcode;
    logic           unused_operand;
    logic           in_wait, tmo_clr, tmo_inc, tmo_expire, set_bus_err;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic           set_illegal;
`endif

    assign opcode         = ir_in[7 -: OPW];
    assign unused_operand = ^ir_in[7-OPW:0];
    assign in_wait        = state inside {ST_FETCH_RD, ST_MEM_RD, ST_MEM_WR};
    assign tmo_inc        = in_wait && !mem_ready;
    assign tmo_clr        = !in_wait || mem_ready;
    assign state_dbg      = state;
    assign halted         = (state == ST_HALT);

    ctrl_timeout_cnt #(
        .LIMIT (TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (tmo_clr),
        .inc    (tmo_inc),
        .expire (tmo_expire)
    );

    always_comb begin
        state_n     = state;
        set_bus_err = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
        set_illegal = 1'b0;
`endif
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        mar_src  = 1'b0;
        mar_load = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        ir_load  = 1'b0;
        acc_load = 1'b0;
        alu_op   = ALU_PASS;
        out_load = 1'b0;

        case (state)
            ST_FETCH: begin
                mar_load = 1'b1;
                state_n  = ST_FETCH_RD;
            end
            ST_FETCH_RD: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                    state_n = ST_DECODE;
                end else if (tmo_expire) begin
                    set_bus_err = 1'b1;
                    state_n     = ST_HALT;
                end
            end
            ST_DECODE: begin
                state_n = ST_FETCH;
                case (opcode)
                    OPW'(OP_NOP): ;
                    OPW'(OP_LDA), OPW'(OP_ADD), OPW'(OP_SUB): begin
                        mar_src  = 1'b1;
                        mar_load = 1'b1;
                        state_n  = ST_MEM_RD;
                    end
                    OPW'(OP_STA): begin
                        mar_src  = 1'b1;
                        mar_load = 1'b1;
                        state_n  = ST_MEM_WR;
                    end
                    OPW'(OP_JMP): pc_load  = 1'b1;
                    OPW'(OP_JZ):  pc_load  = zero_flag;
                    OPW'(OP_OUT): out_load = 1'b1;
                    OPW'(OP_HLT): state_n  = ST_HALT;
                    default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                        set_illegal = 1'b1;
                        state_n     = ST_HALT;
`else
                        state_n     = ST_FETCH;
`endif
                    end
                endcase
            end
            ST_MEM_RD: begin
                mem_rd = 1'b1;
                case (opcode)
                    OPW'(OP_ADD): alu_op = ALU_ADD;
                    OPW'(OP_SUB): alu_op = ALU_SUB;
                    default:      alu_op = ALU_PASS;
                endcase
                if (mem_ready) begin
                    acc_load = 1'b1;
                    state_n  = ST_FETCH;
                end else if (tmo_expire) begin
                    set_bus_err = 1'b1;
                    state_n     = ST_HALT;
                end
            end
            ST_MEM_WR: begin
                mem_wr = 1'b1;
                if (mem_ready) begin
                    state_n = ST_FETCH;
                end else if (tmo_expire) begin
                    set_bus_err = 1'b1;
                    state_n     = ST_HALT;
                end
            end
            ST_HALT: ;
            default: state_n = ST_FETCH;
        endcase

        // Reset must silence the datapath even mid-handshake.
        if (rst) begin
            pc_inc   = 1'b0;
            pc_load  = 1'b0;
            mar_src  = 1'b0;
            mar_load = 1'b0;
            mem_rd   = 1'b0;
            mem_wr   = 1'b0;
            ir_load  = 1'b0;
            acc_load = 1'b0;
            alu_op   = ALU_PASS;
            out_load = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_FETCH;
            bus_err <= 1'b0;
        end else begin
            state <= state_n;
            if (set_bus_err) begin
                bus_err <= 1'b1;
            end
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_op <= 1'b0;
        end else if (set_illegal) begin
            illegal_op <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer: per-cycle state and strobe vectors against hand-derived tables.
module tb_ctrl_sequencer;

    logic       clk = 1'b0;
    logic       rst, mem_ready, zero_flag;
    logic [7:0] ir_in;
    logic       pc_inc, pc_load, mar_src, mar_load, mem_rd, mem_wr, ir_load, acc_load;
    logic [1:0] alu_op;
    logic       out_load, halted, bus_err;
    logic [2:0] state_dbg;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic       illegal_op;
`endif

    int checks   = 0;
    int failures = 0;

    ctrl_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .ir_in     (ir_in),
        .mem_ready (mem_ready),
        .zero_flag (zero_flag),
        .pc_inc    (pc_inc),
        .pc_load   (pc_load),
        .mar_src   (mar_src),
        .mar_load  (mar_load),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .ir_load   (ir_load),
        .acc_load  (acc_load),
        .alu_op    (alu_op),
        .out_load  (out_load),
        .halted    (halted),
        .bus_err   (bus_err),
        .state_dbg (state_dbg)
`ifdef CTRL_ILLEGAL_TRAP_EN
        ,
        .illegal_op (illegal_op)
`endif
    );

    always #5 clk = ~clk;

    // Bit order: pc_inc pc_load mar_src mar_load mem_rd mem_wr ir_load acc_load alu_op[1:0] out_load halted bus_err
    wire [12:0] strb = {pc_inc, pc_load, mar_src, mar_load, mem_rd, mem_wr, ir_load,
                        acc_load, alu_op, out_load, halted, bus_err};

    localparam logic [12:0] B_PCI  = 13'h1000;
    localparam logic [12:0] B_PCL  = 13'h0800;
    localparam logic [12:0] B_MSRC = 13'h0400;
    localparam logic [12:0] B_MLD  = 13'h0200;
    localparam logic [12:0] B_MRD  = 13'h0100;
    localparam logic [12:0] B_MWR  = 13'h0080;
    localparam logic [12:0] B_IRL  = 13'h0040;
    localparam logic [12:0] B_ACC  = 13'h0020;
    localparam logic [12:0] B_SUB  = 13'h0010;
    localparam logic [12:0] B_ADD  = 13'h0008;
    localparam logic [12:0] B_OUT  = 13'h0004;
    localparam logic [12:0] B_HLT  = 13'h0002;
    localparam logic [12:0] B_BERR = 13'h0001;
    localparam logic [12:0] B_NONE = 13'h0000;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; ir_in = 8'h00; mem_ready = 1'b1; zero_flag = 1'b0;
        #1;
        checks++;
        if (strb[12:2] !== 11'h0) begin
            failures++;
            $display("FAIL reset_gate_pre got strobes=%b required=0", strb[12:2]);
        end
        tick; tick;
        checks++;
        if ({state_dbg, strb} !== {3'd0, B_NONE}) begin
            failures++;
            $display("FAIL reset_state got st=%0d strb=%b required st=0 strb=0", state_dbg, strb);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({state_dbg, strb} !== {3'd0, B_MLD}) begin
            failures++;
            $display("FAIL reset_release got st=%0d strb=%b required st=0 strb=%b", state_dbg, strb, B_MLD);
        end
    endtask

    task automatic test_fetch_nop;
        logic [2:0]  es [4];
        logic [12:0] ev [4];
        es[0] = 3'd0; ev[0] = B_MLD;
        es[1] = 3'd1; ev[1] = B_MRD | B_IRL | B_PCI;
        es[2] = 3'd2; ev[2] = B_NONE;
        es[3] = 3'd0; ev[3] = B_MLD;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick;
            ir_in = 8'h00; mem_ready = 1'b1;
            #1;
            checks++;
            if ({state_dbg, strb} !== {es[i], ev[i]}) begin
                failures++;
                $display("FAIL fetch_nop t%0d got st=%0d strb=%b required st=%0d strb=%b",
                         i, state_dbg, strb, es[i], ev[i]);
            end
        end
    endtask

    task automatic test_opcodes;
        logic [7:0]  ir  [7];
        logic [12:0] dec [7];
        logic [2:0]  nst [7];
        logic [12:0] nex [7];
        ir[0] = 8'h00; dec[0] = B_NONE;         nst[0] = 3'd0; nex[0] = B_MLD;
        ir[1] = 8'h1C; dec[1] = B_MSRC | B_MLD; nst[1] = 3'd3; nex[1] = B_MRD | B_ACC;
        ir[2] = 8'h27; dec[2] = B_MSRC | B_MLD; nst[2] = 3'd4; nex[2] = B_MWR;
        ir[3] = 8'h35; dec[3] = B_MSRC | B_MLD; nst[3] = 3'd3; nex[3] = B_MRD | B_ADD | B_ACC;
        ir[4] = 8'h43; dec[4] = B_MSRC | B_MLD; nst[4] = 3'd3; nex[4] = B_MRD | B_SUB | B_ACC;
        ir[5] = 8'h59; dec[5] = B_PCL;          nst[5] = 3'd0; nex[5] = B_MLD;
        ir[6] = 8'h71; dec[6] = B_OUT;          nst[6] = 3'd0; nex[6] = B_MLD;
        for (int i = 0; i < 7; i++) begin
            ir_in = ir[i]; mem_ready = 1'b1; zero_flag = 1'b0;
            tick; tick;
            #1;
            checks++;
            if ({state_dbg, strb} !== {3'd2, dec[i]}) begin
                failures++;
                $display("FAIL op_decode ir=%h got st=%0d strb=%b required st=2 strb=%b",
                         ir[i], state_dbg, strb, dec[i]);
            end
            tick;
            #1;
            checks++;
            if ({state_dbg, strb} !== {nst[i], nex[i]}) begin
                failures++;
                $display("FAIL op_exec ir=%h got st=%0d strb=%b required st=%0d strb=%b",
                         ir[i], state_dbg, strb, nst[i], nex[i]);
            end
            if (nst[i] != 3'd0) begin
                tick;
                #1;
                checks++;
                if ({state_dbg, strb} !== {3'd0, B_MLD}) begin
                    failures++;
                    $display("FAIL op_return ir=%h got st=%0d strb=%b required st=0 strb=%b",
                             ir[i], state_dbg, strb, B_MLD);
                end
            end
        end
    endtask

    task automatic test_add_wait;
        logic        rdy [7];
        logic [2:0]  es  [7];
        logic [12:0] ev  [7];
        rdy[0] = 1'b1; es[0] = 3'd0; ev[0] = B_MLD;
        rdy[1] = 1'b1; es[1] = 3'd1; ev[1] = B_MRD | B_IRL | B_PCI;
        rdy[2] = 1'b0; es[2] = 3'd2; ev[2] = B_MSRC | B_MLD;
        rdy[3] = 1'b0; es[3] = 3'd3; ev[3] = B_MRD | B_ADD;
        rdy[4] = 1'b0; es[4] = 3'd3; ev[4] = B_MRD | B_ADD;
        rdy[5] = 1'b1; es[5] = 3'd3; ev[5] = B_MRD | B_ADD | B_ACC;
        rdy[6] = 1'b1; es[6] = 3'd0; ev[6] = B_MLD;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) tick;
            ir_in = 8'h35; mem_ready = rdy[i];
            #1;
            checks++;
            if ({state_dbg, strb} !== {es[i], ev[i]}) begin
                failures++;
                $display("FAIL add_wait t%0d got st=%0d strb=%b required st=%0d strb=%b",
                         i, state_dbg, strb, es[i], ev[i]);
            end
        end
    endtask

    task automatic test_jz;
        for (int z = 1; z >= 0; z--) begin
            ir_in = 8'h6A; mem_ready = 1'b1; zero_flag = z[0];
            tick; tick;
            #1;
            checks++;
            if ({state_dbg, strb} !== {3'd2, (z == 1) ? B_PCL : B_NONE}) begin
                failures++;
                $display("FAIL jz_decode zf=%0d got st=%0d strb=%b required pc_load=%0d in st=2",
                         z, state_dbg, strb, z);
            end
            tick;
            #1;
            checks++;
            if ({state_dbg, strb} !== {3'd0, B_MLD}) begin
                failures++;
                $display("FAIL jz_return zf=%0d got st=%0d strb=%b required st=0 strb=%b",
                         z, state_dbg, strb, B_MLD);
            end
        end
    endtask

    task automatic test_illegal_hlt;
        ir_in = 8'h93; mem_ready = 1'b1; zero_flag = 1'b0;
        tick; tick;
        #1;
        checks++;
        if ({state_dbg, strb} !== {3'd2, B_NONE}) begin
            failures++;
            $display("FAIL illegal_decode got st=%0d strb=%b required st=2 strb=0", state_dbg, strb);
        end
        tick;
        #1;
`ifdef CTRL_ILLEGAL_TRAP_EN
        checks++;
        if ({illegal_op, state_dbg, strb} !== {1'b1, 3'd5, B_HLT}) begin
            failures++;
            $display("FAIL illegal_trap got ill=%b st=%0d strb=%b required ill=1 st=5 strb=%b",
                     illegal_op, state_dbg, strb, B_HLT);
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        #1;
        checks++;
        if ({illegal_op, state_dbg, strb} !== {1'b0, 3'd0, B_MLD}) begin
            failures++;
            $display("FAIL illegal_clear got ill=%b st=%0d strb=%b required ill=0 st=0",
                     illegal_op, state_dbg, strb);
        end
`else
        checks++;
        if ({state_dbg, strb} !== {3'd0, B_MLD}) begin
            failures++;
            $display("FAIL illegal_as_nop got st=%0d strb=%b required st=0 strb=%b",
                     state_dbg, strb, B_MLD);
        end
`endif
        ir_in = 8'hF0;
        tick; tick;
        #1;
        checks++;
        if ({state_dbg, strb} !== {3'd2, B_NONE}) begin
            failures++;
            $display("FAIL hlt_decode got st=%0d strb=%b required st=2 strb=0", state_dbg, strb);
        end
        for (int i = 0; i < 4; i++) begin
            tick;
            mem_ready = i[0]; zero_flag = ~i[0]; ir_in = (i == 0) ? 8'hF0 : 8'h35;
            #1;
            checks++;
            if ({state_dbg, strb} !== {3'd5, B_HLT}) begin
                failures++;
                $display("FAIL hlt_hold c%0d got st=%0d strb=%b required st=5 strb=%b",
                         i, state_dbg, strb, B_HLT);
            end
        end
        rst = 1'b1;
        tick;
        rst = 1'b0; ir_in = 8'h00; mem_ready = 1'b1; zero_flag = 1'b0;
        #1;
        checks++;
        if ({state_dbg, strb} !== {3'd0, B_MLD}) begin
            failures++;
            $display("FAIL hlt_exit got st=%0d strb=%b required st=0 strb=%b", state_dbg, strb, B_MLD);
        end
    endtask

    task automatic test_timeout;
        ir_in = 8'h00; zero_flag = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            tick;
            mem_ready = 1'b0;
            #1;
            checks++;
            if ({state_dbg, strb} !== {3'd1, B_MRD}) begin
                failures++;
                $display("FAIL tmo_wait c%0d got st=%0d strb=%b required st=1 strb=%b",
                         c, state_dbg, strb, B_MRD);
            end
        end
        for (int i = 0; i < 2; i++) begin
            tick;
            mem_ready = i[0];
            #1;
            checks++;
            if ({state_dbg, strb} !== {3'd5, B_HLT | B_BERR}) begin
                failures++;
                $display("FAIL tmo_halt h%0d got st=%0d strb=%b required st=5 strb=%b",
                         i, state_dbg, strb, B_HLT | B_BERR);
            end
        end
        rst = 1'b1;
        tick;
        #1;
        checks++;
        if ({state_dbg, strb} !== {3'd0, B_NONE}) begin
            failures++;
            $display("FAIL tmo_reset got st=%0d strb=%b required st=0 strb=0", state_dbg, strb);
        end
        rst = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            tick;
            mem_ready = (c == 15);
            #1;
            checks++;
            if ({state_dbg, strb} !== {3'd1, (c == 15) ? (B_MRD | B_IRL | B_PCI) : B_MRD}) begin
                failures++;
                $display("FAIL tmo_edge c%0d got st=%0d strb=%b required st=1 ready=%0d",
                         c, state_dbg, strb, c == 15);
            end
        end
        tick;
        mem_ready = 1'b1;
        #1;
        checks++;
        if ({state_dbg, strb} !== {3'd2, B_NONE}) begin
            failures++;
            $display("FAIL tmo_edge_done got st=%0d strb=%b required st=2 strb=0", state_dbg, strb);
        end
        tick;
        #1;
    endtask

    task automatic test_reset_mid;
        ir_in = 8'h1C; mem_ready = 1'b1; zero_flag = 1'b0;
        tick;
        mem_ready = 1'b1;
        tick;
        mem_ready = 1'b0;
        tick;
        #1;
        checks++;
        if ({state_dbg, strb} !== {3'd3, B_MRD}) begin
            failures++;
            $display("FAIL rmid_memrd got st=%0d strb=%b required st=3 strb=%b", state_dbg, strb, B_MRD);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (strb[12:2] !== 11'h0) begin
            failures++;
            $display("FAIL rmid_gate got strobes=%b required=0", strb[12:2]);
        end
        tick;
        checks++;
        if ({state_dbg, strb} !== {3'd0, B_NONE}) begin
            failures++;
            $display("FAIL rmid_hold got st=%0d strb=%b required st=0 strb=0", state_dbg, strb);
        end
        tick;
        rst = 1'b0;
        #1;
        checks++;
        if ({state_dbg, strb} !== {3'd0, B_MLD}) begin
            failures++;
            $display("FAIL rmid_release got st=%0d strb=%b required st=0 strb=%b",
                     state_dbg, strb, B_MLD);
        end
    endtask

    initial begin
        test_reset;
        test_fetch_nop;
        test_opcodes;
        test_add_wait;
        test_jz;
        test_illegal_hlt;
        test_timeout;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "bench time limit");
    end

endmodule
